// File: rtl/dff_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dff_mem_ctrl : flip-flop RAM with MAR, auto-increment, registered reads  |
// |                and post-reset clear; parity option DFF_MEM_PARITY_EN     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module dff_mem_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AUTO_INC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              lm_n,
  input  logic              lr_n,
  input  logic              ce_n,
  input  logic [DATA_W-1:0] data_in,
`ifdef DFF_MEM_PARITY_EN
  input  logic              force_par_n,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              parity_err
);

`ifdef DFF_MEM_PARITY_EN
  localparam int C_WORD_W = DATA_W + 1;
`else
  localparam int C_WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                parity_err_q, parity_err_d;
  logic [C_WORD_W-1:0] mem_q [DEPTH];
  logic [C_WORD_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0]   w_ea;
  logic [C_WORD_W-1:0] w_rd_word;
  logic [C_WORD_W-1:0] w_wr_word;

  // Out-of-range addresses match no word, so reads yield zero and writes drop
  always_comb begin
    w_ea      = (!lm_n) ? mar_in : mar_q;
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ea == ADDR_W'(i)) w_rd_word = mem_q[i];
    end
`ifdef DFF_MEM_PARITY_EN
    w_wr_word = {(^data_in) ^ ~force_par_n, data_in};
`else
    w_wr_word = data_in;
`endif
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    mar_d        = mar_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    mem_d        = mem_q;
    case (state_q)
      ST_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (clr_cnt_q == ADDR_W'(i)) mem_d[i] = '0;
        end
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == C_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!lr_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_ea == ADDR_W'(i)) mem_d[i] = w_wr_word;
          end
        end else if (!ce_n) begin
          data_valid_d = 1'b1;
          data_out_d   = w_rd_word[DATA_W-1:0];
`ifdef DFF_MEM_PARITY_EN
          parity_err_d = w_rd_word[DATA_W] ^ (^w_rd_word[DATA_W-1:0]);
`endif
        end
        // ea >= DEPTH-1 covers both the last word and any out-of-range address
        if (!lr_n || !ce_n) begin
          if (AUTO_INC != 0) mar_d = (w_ea >= C_LAST) ? '0 : w_ea + ADDR_W'(1);
          else               mar_d = w_ea;
        end else if (!lm_n) begin
          mar_d = mar_in;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      mar_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      mar_q        <= mar_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_dff_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dff_mem_ctrl : directed bench for dff_mem_ctrl (three configurations) |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_dff_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mar_in  [3];
  logic       lm_n    [3];
  logic       lr_n    [3];
  logic       ce_n    [3];
  logic [7:0] data_in [3];
  logic [7:0] dout    [3];
  logic       dv      [3];
  logic       bsy     [3];
  logic       perr    [3];
`ifdef DFF_MEM_PARITY_EN
  logic       force_par_n = 1'b1;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // 0: 16 words, no increment; 1: 16 words, auto-increment; 2: 10 words, auto-increment
  dff_mem_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst(rst), .mar_in(mar_in[0]), .lm_n(lm_n[0]), .lr_n(lr_n[0]),
    .ce_n(ce_n[0]), .data_in(data_in[0]),
`ifdef DFF_MEM_PARITY_EN
    .force_par_n(force_par_n),
`endif
    .data_out(dout[0]), .data_valid(dv[0]), .busy(bsy[0]), .parity_err(perr[0]));

  dff_mem_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst(rst), .mar_in(mar_in[1]), .lm_n(lm_n[1]), .lr_n(lr_n[1]),
    .ce_n(ce_n[1]), .data_in(data_in[1]),
`ifdef DFF_MEM_PARITY_EN
    .force_par_n(force_par_n),
`endif
    .data_out(dout[1]), .data_valid(dv[1]), .busy(bsy[1]), .parity_err(perr[1]));

  dff_mem_ctrl #(.DATA_W(8), .DEPTH(10), .ADDR_W(4), .AUTO_INC(1)) u_dut2 (
    .clk(clk), .rst(rst), .mar_in(mar_in[2]), .lm_n(lm_n[2]), .lr_n(lr_n[2]),
    .ce_n(ce_n[2]), .data_in(data_in[2]),
`ifdef DFF_MEM_PARITY_EN
    .force_par_n(force_par_n),
`endif
    .data_out(dout[2]), .data_valid(dv[2]), .busy(bsy[2]), .parity_err(perr[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int i, input logic lm, input logic lr, input logic ce,
                      input logic [3:0] mar, input logic [7:0] din);
    lm_n[i] = lm; lr_n[i] = lr; ce_n[i] = ce; mar_in[i] = mar; data_in[i] = din;
    @(posedge clk); #1;
    lm_n[i] = 1'b1; lr_n[i] = 1'b1; ce_n[i] = 1'b1;
  endtask

  task automatic rdchk(input int i, input logic lm, input logic [3:0] mar,
                       input logic [7:0] exp, input string tag);
    step(i, lm, 1'b1, 1'b0, mar, 8'h00);
    chk({tag, ".data"}, 32'(dout[i]), 32'(exp));
    chk({tag, ".valid"}, 32'(dv[i]), 32'd1);
  endtask

  initial begin
    int cnt [3];
    int n;
    logic seen_v;
    for (int i = 0; i < 3; i++) begin
      mar_in[i] = '0; lm_n[i] = 1'b1; lr_n[i] = 1'b1; ce_n[i] = 1'b1; data_in[i] = '0;
      cnt[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("rst.busy", 32'(bsy[i]), 32'd1);
    chk("rst.data", 32'(dout[0]), 32'd0);
    chk("rst.valid", 32'(dv[0]), 32'd0);
    chk("rst.perr", 32'(perr[0]), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 3; i++) if (bsy[i]) cnt[i]++;
      @(posedge clk); #1;
    end
    chk("clear.len0", 32'(cnt[0]), 32'd16);
    chk("clear.len1", 32'(cnt[1]), 32'd16);
    chk("clear.len2", 32'(cnt[2]), 32'd10);
    chk("idle.busy", 32'(bsy[0]), 32'd0);

    for (int k = 0; k < 16; k++) rdchk(0, 1'b0, 4'(k), 8'h00, "t1.rd");
    step(0, 1'b1, 1'b1, 1'b1, 4'd0, 8'h00);
    chk("t1.pulse", 32'(dv[0]), 32'd0);

    step(0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h00);
    step(0, 1'b1, 1'b0, 1'b1, 4'd0, 8'hA5);
    rdchk(0, 1'b1, 4'd0, 8'hA5, "t2.rd");
    step(0, 1'b1, 1'b1, 1'b1, 4'd0, 8'h00);
    chk("t2.pulse", 32'(dv[0]), 32'd0);
    chk("t2.hold", 32'(dout[0]), 32'hA5);
    rdchk(0, 1'b1, 4'd0, 8'hA5, "t2.mar");

    step(0, 1'b0, 1'b0, 1'b0, 4'd3, 8'h3C);
    chk("t4.valid", 32'(dv[0]), 32'd0);
    chk("t4.hold", 32'(dout[0]), 32'hA5);
    rdchk(0, 1'b0, 4'd3, 8'h3C, "t4.rd");

    step(0, 1'b0, 1'b0, 1'b1, 4'd8, 8'h5A);
    rdchk(0, 1'b1, 4'd0, 8'h5A, "raw");

    step(1, 1'b0, 1'b1, 1'b1, 4'd15, 8'h00);
    step(1, 1'b1, 1'b0, 1'b1, 4'd0, 8'h11);
    step(1, 1'b1, 1'b0, 1'b1, 4'd0, 8'h22);
    rdchk(1, 1'b0, 4'd15, 8'h11, "t3.w15");
    rdchk(1, 1'b1, 4'd0, 8'h22, "t3.w0");
    rdchk(1, 1'b1, 4'd0, 8'h00, "t3.w1");

    step(2, 1'b0, 1'b0, 1'b1, 4'd9, 8'h99);
    step(2, 1'b1, 1'b0, 1'b1, 4'd0, 8'h44);
    step(2, 1'b0, 1'b0, 1'b1, 4'd12, 8'h77);
    rdchk(2, 1'b1, 4'd0, 8'h44, "oor.wrapw");
    rdchk(2, 1'b0, 4'd12, 8'h00, "oor.rd");
    rdchk(2, 1'b1, 4'd0, 8'h44, "oor.wrapr");
    rdchk(2, 1'b0, 4'd9, 8'h99, "last.rd");
    rdchk(2, 1'b1, 4'd0, 8'h44, "last.wrap");
    rdchk(2, 1'b0, 4'd2, 8'h00, "oor.alias");

`ifdef DFF_MEM_PARITY_EN
    force_par_n = 1'b0;
    step(0, 1'b0, 1'b0, 1'b1, 4'd2, 8'h07);
    force_par_n = 1'b1;
    rdchk(0, 1'b0, 4'd2, 8'h07, "t6.bad");
    chk("t6.perr1", 32'(perr[0]), 32'd1);
    step(0, 1'b0, 1'b0, 1'b1, 4'd4, 8'h07);
    rdchk(0, 1'b0, 4'd4, 8'h07, "t6.good");
    chk("t6.perr0", 32'(perr[0]), 32'd0);
`endif

    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5.rst.data", 32'(dout[0]), 32'd0);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t5.midclear", 32'(bsy[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lm_n[0] = 1'b0; lr_n[0] = 1'b0; mar_in[0] = 4'd5; data_in[0] = 8'hFF;
    lm_n[1] = 1'b0; ce_n[1] = 1'b0; mar_in[1] = 4'd15;
    n = 0;
    seen_v = 1'b0;
    while (bsy[0] && n < 60) begin
      n++;
      @(posedge clk); #1;
      if (dv[1]) seen_v = 1'b1;
    end
    lm_n[0] = 1'b1; lr_n[0] = 1'b1;
    lm_n[1] = 1'b1; ce_n[1] = 1'b1;
    chk("t5.len", 32'(n), 32'd16);
    chk("t5.busyvalid", 32'(seen_v), 32'd0);
    step(0, 1'b1, 1'b0, 1'b1, 4'd0, 8'h66);
    for (int k = 0; k < 16; k++) rdchk(0, 1'b0, 4'(k), (k == 0) ? 8'h66 : 8'h00, "t5.rd");
    step(1, 1'b1, 1'b0, 1'b1, 4'd0, 8'hBB);
    rdchk(1, 1'b0, 4'd0, 8'hBB, "t5.mar1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
